// File: rtl/bft_leaf_endpoint.sv
// Host-side peer of a single-in/single-out BFT leaf: 32-bit user stream <-> 49-bit packets.
// Optional RX sequence checking is enabled by defining BFT_ENDPOINT_SEQ_CHECK_EN.
`timescale 1ns/1ps

module bft_leaf_endpoint #(
  parameter int         PACKET_BITS  = 49,
  parameter int         PAYLOAD_BITS = 32,
  parameter logic [3:0] DEST_LEAF    = 4'd2,
  parameter logic [3:0] DEST_PORT    = 4'd1,
  parameter int         INIT_CREDITS = 128,
  parameter int         RX_FIFO_AW   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [PAYLOAD_BITS-1:0] din_endpoint_user,
  input  logic                    vld_user2endpoint,
  output logic                    ack_endpoint2user,
  output logic [PACKET_BITS-1:0]  dout_endpoint_bft,
  input  logic [PACKET_BITS-1:0]  din_bft_endpoint,
  output logic [PAYLOAD_BITS-1:0] dout_endpoint_user,
  output logic                    vld_endpoint2user,
  input  logic                    ack_user2endpoint,
  output logic [7:0]              credits,
  output logic                    seq_err
);

  // Handshakes on both user ports: a word moves in a cycle where valid and ack are
  // both high at the rising edge; valid never waits on ack, ack is free to depend on state.

  localparam int SEQ_BITS  = 7;
  localparam int TYPE_BIT  = PAYLOAD_BITS;
  localparam int SEQ_LSB   = PAYLOAD_BITS + 1;
  localparam int VALID_BIT = PACKET_BITS - 1;
  localparam int DEPTH     = 1 << RX_FIFO_AW;
  localparam logic [8:0] CREDIT_MAX = 9'(INIT_CREDITS);

  // Incoming packet decode
  logic                    in_valid;
  logic                    in_type;
  logic [SEQ_BITS-1:0]     in_seq;
  logic [PAYLOAD_BITS-1:0] in_payload;
  logic                    rx_data_pkt;
  logic                    fs_pkt;
  logic                    unused_fields;

  assign in_valid    = din_bft_endpoint[VALID_BIT];
  assign in_type     = din_bft_endpoint[TYPE_BIT];
  assign in_seq      = din_bft_endpoint[SEQ_LSB +: SEQ_BITS];
  assign in_payload  = din_bft_endpoint[PAYLOAD_BITS-1:0];
  assign rx_data_pkt = in_valid && !in_type;
  assign fs_pkt      = in_valid && in_type;

  // Leaf/port of returning packets are never inspected.
  assign unused_fields = ^din_bft_endpoint[VALID_BIT-1:SEQ_LSB];

  // ---------------- TX path ----------------
  logic                tx_fire;
  logic [SEQ_BITS-1:0] tx_seq;

  assign ack_endpoint2user = (credits != 8'd0) && !reset;
  assign tx_fire           = vld_user2endpoint && ack_endpoint2user;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout_endpoint_bft <= '0;
      tx_seq            <= '0;
    end else if (tx_fire) begin
      dout_endpoint_bft <= {1'b1, DEST_LEAF, DEST_PORT, tx_seq, 1'b0, din_endpoint_user};
      tx_seq            <= tx_seq + 7'd1;
    end else begin
      dout_endpoint_bft <= '0;
    end
  end

  // ---------------- Credits ----------------
  logic [8:0] credit_sum;
  logic [7:0] credits_next;

  // A send only happens with credits >= 1, so the subtraction cannot underflow.
  always_comb begin
    credit_sum = {1'b0, credits} - {8'd0, tx_fire};
    if (fs_pkt) begin
      credit_sum = credit_sum + {1'b0, in_payload[7:0]};
    end
    credits_next = (credit_sum > CREDIT_MAX) ? CREDIT_MAX[7:0] : credit_sum[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      credits <= CREDIT_MAX[7:0];
    end else begin
      credits <= credits_next;
    end
  end

  // ---------------- RX FIFO ----------------
  logic [PAYLOAD_BITS-1:0] rx_mem [DEPTH];
  logic [RX_FIFO_AW:0]     wr_ptr;
  logic [RX_FIFO_AW:0]     rd_ptr;
  logic                    fifo_empty;
  logic                    fifo_full;
  logic                    fifo_pop;
  logic                    fifo_push;
  logic                    fifo_overflow;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[RX_FIFO_AW] != rd_ptr[RX_FIFO_AW]) &&
                      (wr_ptr[RX_FIFO_AW-1:0] == rd_ptr[RX_FIFO_AW-1:0]);
  assign fifo_pop   = !fifo_empty && ack_user2endpoint;
  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign fifo_push     = rx_data_pkt && (!fifo_full || fifo_pop);
  assign fifo_overflow = rx_data_pkt && fifo_full && !fifo_pop;

  always_ff @(posedge clk) begin
    if (fifo_push) begin
      rx_mem[wr_ptr[RX_FIFO_AW-1:0]] <= in_payload;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (fifo_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (fifo_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  assign vld_endpoint2user  = !fifo_empty;
  assign dout_endpoint_user = fifo_empty ? '0 : rx_mem[rd_ptr[RX_FIFO_AW-1:0]];

  // ---------------- Sequence check ----------------
  logic seq_mismatch;

`ifdef BFT_ENDPOINT_SEQ_CHECK_EN
  logic [SEQ_BITS-1:0] rx_exp_seq;

  assign seq_mismatch = rx_data_pkt && (in_seq != rx_exp_seq);

  // Resync to the received seq: on a match this equals the normal increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_exp_seq <= '0;
    end else if (rx_data_pkt) begin
      rx_exp_seq <= in_seq + 7'd1;
    end
  end
`else
  assign seq_mismatch = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seq_err <= 1'b0;
    end else if (fifo_overflow || seq_mismatch) begin
      seq_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bft_leaf_endpoint.sv
// Directed bench for bft_leaf_endpoint: TX and RX expected queues checked by free-running monitors.
`timescale 1ns/1ps

module tb_bft_leaf_endpoint;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] din_endpoint_user;
  logic        vld_user2endpoint;
  logic        ack_endpoint2user;
  logic [48:0] dout_endpoint_bft;
  logic [48:0] din_bft_endpoint;
  logic [31:0] dout_endpoint_user;
  logic        vld_endpoint2user;
  logic        ack_user2endpoint;
  logic [7:0]  credits;
  logic        seq_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [48:0] tx_exp_q[$];
  logic [31:0] rx_exp_q[$];
  logic [6:0]  tx_seq_m = 7'd0;

`ifdef BFT_ENDPOINT_SEQ_CHECK_EN
  localparam logic SEQ_ERR_EXP = 1'b1;
`else
  localparam logic SEQ_ERR_EXP = 1'b0;
`endif

  bft_leaf_endpoint dut (
    .clk                (clk),
    .reset              (reset),
    .din_endpoint_user  (din_endpoint_user),
    .vld_user2endpoint  (vld_user2endpoint),
    .ack_endpoint2user  (ack_endpoint2user),
    .dout_endpoint_bft  (dout_endpoint_bft),
    .din_bft_endpoint   (din_bft_endpoint),
    .dout_endpoint_user (dout_endpoint_user),
    .vld_endpoint2user  (vld_endpoint2user),
    .ack_user2endpoint  (ack_user2endpoint),
    .credits            (credits),
    .seq_err            (seq_err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [48:0] fs_pkt(input logic [7:0] n);
    return {1'b1, 4'h0, 4'h0, 7'd0, 1'b1, 24'd0, n};
  endfunction

  function automatic logic [48:0] data_pkt(input logic [6:0] s, input logic [31:0] d);
    return {1'b1, 4'h3, 4'h0, s, 1'b0, d};
  endfunction

  // All drivers start and end just after a rising edge.
  task automatic send_word(input logic [31:0] d);
    bit got;
    got = 1'b0;
    vld_user2endpoint = 1'b1;
    din_endpoint_user = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ack_endpoint2user) begin
        got = 1'b1;
        break;
      end
    end
    check("tx_ack_wait", 64'(got), 64'd1);
    if (got) begin
      tx_exp_q.push_back({1'b1, 4'd2, 4'd1, tx_seq_m, 1'b0, d});
      tx_seq_m++;
    end
    @(posedge clk); #1;
    vld_user2endpoint = 1'b0;
  endtask

  task automatic send_pkt(input logic [48:0] p);
    din_bft_endpoint = p;
    @(posedge clk); #1;
    din_bft_endpoint = '0;
  endtask

  task automatic chk_credits(input string name, input logic [7:0] exp);
    @(negedge clk);
    check(name, 64'(credits), 64'(exp));
    @(posedge clk); #1;
  endtask

  task automatic check_reset_values();
    check("rst_dout_bft", 64'(dout_endpoint_bft), 64'd0);
    check("rst_ack", 64'(ack_endpoint2user), 64'd0);
    check("rst_vld", 64'(vld_endpoint2user), 64'd0);
    check("rst_dout_user", 64'(dout_endpoint_user), 64'd0);
    check("rst_credits", 64'(credits), 64'd128);
    check("rst_seq_err", 64'(seq_err), 64'd0);
  endtask

  task automatic wait_rx_drain();
    for (int i = 0; i < 40 && rx_exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    check("rx_drained", 64'(rx_exp_q.size()), 64'd0);
    @(negedge clk);
    check("rx_vld_after_drain", 64'(vld_endpoint2user), 64'd0);
    @(posedge clk); #1;
  endtask

  // ---------------- scoreboard monitors ----------------
  always @(negedge clk) begin
    if (dout_endpoint_bft[48]) begin
      if (tx_exp_q.size() == 0) begin
        check("tx_unexpected_pkt", 64'(dout_endpoint_bft), 64'd0);
      end else begin
        check("tx_pkt", 64'(dout_endpoint_bft), 64'(tx_exp_q.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (vld_endpoint2user && ack_user2endpoint) begin
      if (rx_exp_q.size() == 0) begin
        check("rx_unexpected_word", 64'(dout_endpoint_user), 64'hdead_0000_0000);
      end else begin
        check("rx_word", 64'(dout_endpoint_user), 64'(rx_exp_q.pop_front()));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset             = 1'b1;
    din_endpoint_user = '0;
    vld_user2endpoint = 1'b0;
    din_bft_endpoint  = '0;
    ack_user2endpoint = 1'b1;
    #1;
    check_reset_values();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Three back-to-back words
    for (int i = 0; i < 3; i++) send_word(32'hA0 + 32'(i));
    chk_credits("credits_after_3", 8'd125);

    // Exhaust the credits
    for (int i = 3; i < 128; i++) send_word(32'hA0 + 32'(i));
    @(negedge clk);
    check("credits_zero", 64'(credits), 64'd0);
    check("ack_low_at_zero", 64'(ack_endpoint2user), 64'd0);
    @(posedge clk); #1;

    // Word 129 held until a freespace update of 4
    vld_user2endpoint = 1'b1;
    din_endpoint_user = 32'h0000_0129;
    repeat (3) begin
      @(negedge clk);
      check("ack_held", 64'(ack_endpoint2user), 64'd0);
    end
    @(posedge clk); #1;
    din_bft_endpoint = fs_pkt(8'd4);
    @(posedge clk); #1;
    din_bft_endpoint = '0;
    @(negedge clk);
    check("credits_after_return4", 64'(credits), 64'd4);
    check("ack_resumed", 64'(ack_endpoint2user), 64'd1);
    tx_exp_q.push_back({1'b1, 4'd2, 4'd1, tx_seq_m, 1'b0, 32'h0000_0129});
    tx_seq_m++;
    @(posedge clk); #1;
    vld_user2endpoint = 1'b0;
    chk_credits("credits_after_129", 8'd3);

    // Return and send in the same cycle
    send_pkt(fs_pkt(8'd2));
    chk_credits("credits_5", 8'd5);
    vld_user2endpoint = 1'b1;
    din_endpoint_user = 32'h5555_AAAA;
    din_bft_endpoint  = fs_pkt(8'd1);
    @(negedge clk);
    check("ack_at_5", 64'(ack_endpoint2user), 64'd1);
    tx_exp_q.push_back({1'b1, 4'd2, 4'd1, tx_seq_m, 1'b0, 32'h5555_AAAA});
    tx_seq_m++;
    @(posedge clk); #1;
    vld_user2endpoint = 1'b0;
    din_bft_endpoint  = '0;
    chk_credits("credits_same_cycle", 8'd5);

    // Saturation
    send_pkt(fs_pkt(8'd95));
    chk_credits("credits_100", 8'd100);
    send_pkt(fs_pkt(8'd200));
    chk_credits("credits_saturated", 8'd128);

    // RX fill to full with the user stalled, then one overflow
    ack_user2endpoint = 1'b0;
    for (int i = 0; i < 16; i++) begin
      din_bft_endpoint = data_pkt(7'(i), 32'hC000_0000 + 32'(i));
      rx_exp_q.push_back(32'hC000_0000 + 32'(i));
      @(posedge clk); #1;
    end
    din_bft_endpoint = '0;
    @(negedge clk);
    check("rx_full_vld", 64'(vld_endpoint2user), 64'd1);
    check("rx_full_no_err", 64'(seq_err), 64'd0);
    @(posedge clk); #1;
    send_pkt(data_pkt(7'd16, 32'hDEAD_BEEF));
    @(negedge clk);
    check("rx_overflow_err", 64'(seq_err), 64'd1);
    check("rx_head_intact", 64'(dout_endpoint_user), 64'hC000_0000);
    @(posedge clk); #1;
    ack_user2endpoint = 1'b1;
    wait_rx_drain();

    // Sequence gap 0,1,3
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    tx_seq_m = 7'd0;
    din_bft_endpoint = data_pkt(7'd0, 32'h5E00_0000);
    rx_exp_q.push_back(32'h5E00_0000);
    @(posedge clk); #1;
    din_bft_endpoint = data_pkt(7'd1, 32'h5E00_0001);
    rx_exp_q.push_back(32'h5E00_0001);
    @(negedge clk);
    check("rx_latency_vld", 64'(vld_endpoint2user), 64'd1);
    @(posedge clk); #1;
    din_bft_endpoint = '0;
    @(negedge clk);
    check("seq_in_order", 64'(seq_err), 64'd0);
    @(posedge clk); #1;
    send_pkt(data_pkt(7'd3, 32'h5E00_0003));
    rx_exp_q.push_back(32'h5E00_0003);
    @(negedge clk);
    check("seq_gap_err", 64'(seq_err), 64'(SEQ_ERR_EXP));
    @(posedge clk); #1;
    wait_rx_drain();

    // Reset mid-burst: 5 RX words queued, credits at 10
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    tx_seq_m = 7'd0;
    ack_user2endpoint = 1'b0;
    for (int i = 0; i < 5; i++) send_pkt(data_pkt(7'(i), 32'hB000_0000 + 32'(i)));
    for (int i = 0; i < 118; i++) send_word(32'hF000_0000 + 32'(i));
    chk_credits("credits_10", 8'd10);
    vld_user2endpoint = 1'b1;
    din_endpoint_user = 32'hFFFF_FFFF;
    @(negedge clk);
    check("pre_reset_vld", 64'(vld_endpoint2user), 64'd1);
    #1;
    reset = 1'b1;
    #1;
    check_reset_values();
    vld_user2endpoint = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    ack_user2endpoint = 1'b1;
    @(negedge clk);
    check("post_reset_credits", 64'(credits), 64'd128);
    check("post_reset_vld", 64'(vld_endpoint2user), 64'd0);
    check("post_reset_ack", 64'(ack_endpoint2user), 64'd1);
    repeat (3) @(negedge clk);

    check("tx_queue_empty", 64'(tx_exp_q.size()), 64'd0);
    check("rx_queue_empty", 64'(rx_exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
